// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU data-port prefetcher.
package msu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } msu_state_e;

  localparam int unsigned MSU_DATA_DEPTH = 8;
  localparam int unsigned MSU_WORD_W     = 16;

endpackage

// File: rtl/msu_byte_fifo.sv
// Byte ring buffer: two-byte or single-byte writes, single-byte reads,
// synchronous flush. Reads on an empty buffer are dropped.
module msu_byte_fifo
  import msu_pkg::*;
#(
  parameter int unsigned DEPTH = MSU_DATA_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   flush_i,
  input  logic                   wr2_i,
  input  logic                   wr1_i,
  input  logic [7:0]             wr_lo_i,
  input  logic [7:0]             wr_hi_i,
  input  logic                   rd_i,
  output logic [7:0]             head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_ok;

  assign rd_ok = rd_i && (count_q != '0);

  // Next pointer/count values; flush overrides everything else
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr2_i) begin
        wr_ptr_d = wr_ptr_q + AW'(2);
        count_d  = count_q + CW'(2);
      end else if (wr1_i) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_d - CW'(1);
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage; contents are only observed while count is non-zero
  always_ff @(posedge CLK) begin
    if (!flush_i) begin
      if (wr2_i) begin
        mem_q[wr_ptr_q]          <= wr_lo_i;
        mem_q[wr_ptr_q + AW'(1)] <= wr_hi_i;
      end else if (wr1_i) begin
        mem_q[wr_ptr_q] <= wr_hi_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/msu_data_prefetch.sv
// MSU $2001 data-port prefetcher: fetches 16-bit words from memory into a
// byte ring buffer ahead of the SNES read pointer, restarting on seek.
module msu_data_prefetch
  import msu_pkg::*;
#(
  parameter int unsigned DEPTH = MSU_DATA_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  seek,
  input  logic [31:0]           seek_addr,
  input  logic                  rd_advance,
  output logic [7:0]            data_out,
  output logic                  data_busy,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [MSU_WORD_W-1:0] mem_din
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  msu_state_e    state_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   fetch_addr_q;
  logic          skip_low_q;
  logic          data_busy_q;
  logic [7:0]    data_out_q, data_out_d;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          room_ok;
  logic          take_data;
  logic          fifo_wr2, fifo_wr1, fifo_rd;

  assign room_ok   = (CW'(DEPTH) - count) >= CW'(2);
  assign take_data = mem_ack && mem_req_q && (state_q == ST_REQ) && !seek;
  assign fifo_wr2  = take_data && !skip_low_q;
  assign fifo_wr1  = take_data && skip_low_q;
  assign fifo_rd   = rd_advance && !seek;

  msu_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .flush_i (seek),
    .wr2_i   (fifo_wr2),
    .wr1_i   (fifo_wr1),
    .wr_lo_i (mem_din[7:0]),
    .wr_hi_i (mem_din[15:8]),
    .rd_i    (fifo_rd),
    .head_o  (head),
    .count_o (count)
  );

  // Fetch FSM with registered request, address and busy flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fetch_addr_q <= '0;
      skip_low_q   <= 1'b0;
      data_busy_q  <= 1'b1;
    end else if (seek) begin
      fetch_addr_q <= {seek_addr[31:1], 1'b0};
      skip_low_q   <= seek_addr[0];
      data_busy_q  <= 1'b1;
      // An ack arriving with the seek closes the handshake, so nothing is
      // left to drain; otherwise the in-flight request must be drained.
      if (mem_req_q && !mem_ack) begin
        state_q <= ST_DRAIN;
      end else begin
        state_q   <= ST_IDLE;
        mem_req_q <= 1'b0;
      end
    end else begin
      if (count != '0) begin
        data_busy_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (room_ok) begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_addr_q;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            fetch_addr_q <= fetch_addr_q + 32'd2;
            skip_low_q   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Head byte follows the buffer while it holds data, else holds
  always_comb begin
    data_out_d = data_out_q;
    if (count != '0) begin
      data_out_d = head;
    end
  end

  // Registered head byte
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign data_busy = data_busy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_msu_data_prefetch.sv
// Directed bench for msu_data_prefetch with a latency-programmable memory responder.
module tb_msu_data_prefetch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        seek = 1'b0;
  logic [31:0] seek_addr = '0;
  logic        rd_advance = 1'b0;
  logic [7:0]  data_out;
  logic        data_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_din = '0;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned lat = 3;
  int unsigned n_ack = 0;
  logic [31:0] req_log [$];
  logic        stab_err = 1'b0;

  always #5 CLK = ~CLK;

  msu_data_prefetch #(.DEPTH(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .seek       (seek),
    .seek_addr  (seek_addr),
    .rd_advance (rd_advance),
    .data_out   (data_out),
    .data_busy  (data_busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_din    (mem_din)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [7:0] t;
    if (a < 32'd8) begin
      t = a[7:0] + 8'd1;
      return t * 8'h11;
    end
    return a[7:0] + 8'h40;
  endfunction

  function automatic logic [15:0] word_at(input logic [31:0] a);
    if (a == 32'h104) return 16'hAA99;
    if (a == 32'h200) return 16'hDEAD;
    return {byte_at(a + 32'd1), byte_at(a)};
  endfunction

  function automatic logic [31:0] log_at(input int unsigned i);
    if (i < req_log.size()) return req_log[i];
    return 32'hBAD0_BAD0;
  endfunction

  // Memory side: ack each request after lat cycles, drop it on reset
  initial begin : mem_model
    logic [31:0] a;
    logic        abort;
    forever begin
      @(posedge CLK); #1;
      if (RST_N && mem_req) begin
        a = mem_addr;
        req_log.push_back(a);
        abort = 1'b0;
        for (int k = 0; k < int'(lat) && !abort; k++) begin
          @(posedge CLK); #1;
          if (!RST_N) abort = 1'b1;
          else if (!mem_req || mem_addr !== a) stab_err = 1'b1;
        end
        if (!abort) begin
          mem_din = word_at(a);
          mem_ack = 1'b1;
          @(posedge CLK); #1;
          mem_ack = 1'b0;
          n_ack++;
        end
      end
    end
  end

  task automatic wait_ack(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (n_ack < target && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n_ack < target) check(tag, n_ack, target);
  endtask

  task automatic wait_busy_low(input string tag);
    int unsigned n = 0;
    while (data_busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (data_busy) check(tag, data_busy, 1'b0);
  endtask

  task automatic req_at(input int unsigned idx, input logic [31:0] exp, input string tag);
    int unsigned n = 0;
    while (req_log.size() <= idx && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, log_at(idx), exp);
  endtask

  task automatic do_seek(input logic [31:0] a);
    seek_addr = a;
    seek = 1'b1;
    @(negedge CLK);
    seek = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  exp_seq [9];
    logic        seen;
    int unsigned idx, a0, n;

    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h48};

    // Reset values
    repeat (2) @(negedge CLK);
    check("rst_data_out", data_out, 32'h0);
    check("rst_busy", data_busy, 32'h1);
    check("rst_mem_req", mem_req, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);

    // Initial fill from address 0, ack latency 3
    RST_N = 1'b1;
    wait_ack(1, "fill_ack1_timeout");
    check("fill_busy_at_ack", data_busy, 32'h1);
    @(negedge CLK);
    check("fill_busy_fall", data_busy, 32'h0);
    check("fill_head", data_out, 32'h11);
    wait_ack(4, "fill_ack4_timeout");
    seen = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      seen |= mem_req;
    end
    check("full_no_req", seen, 32'h0);
    check("fill_req_count", req_log.size(), 32'd4);
    check("fill_first_addr", log_at(0), 32'h0);
    check("fill_last_addr", log_at(3), 32'h6);

    // Drain at one byte per cycle with ack latency 1
    lat = 1;
    rd_advance = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 7) rd_advance = 1'b0;
      check($sformatf("stream_%0d", i), data_out, exp_seq[i]);
    end
    @(negedge CLK);
    check("stream_8", data_out, exp_seq[8]);
    repeat (20) @(negedge CLK);
    check("stream_req_count", req_log.size(), 32'd8);
    check("stream_last_addr", log_at(7), 32'hE);

    // Odd seek with ignored reads while empty
    lat = 3;
    idx = req_log.size();
    a0  = n_ack;
    do_seek(32'h0000_0105);
    check("seek_busy", data_busy, 32'h1);
    rd_advance = 1'b1;
    repeat (3) @(negedge CLK);
    rd_advance = 1'b0;
    req_at(idx, 32'h104, "seek_first_addr");
    wait_busy_low("seek_busy_timeout");
    check("seek_high_byte", data_out, 32'hAA);
    req_at(idx + 1, 32'h106, "seek_next_addr");
    wait_ack(a0 + 2, "seek_ack2_timeout");
    @(negedge CLK);
    rd_advance = 1'b1;
    @(negedge CLK);
    rd_advance = 1'b0;
    @(negedge CLK);
    check("seek_second_byte", data_out, 32'h46);

    // Fetch address wraps past the top of the address space
    lat = 1;
    idx = req_log.size();
    do_seek(32'hFFFF_FFFE);
    req_at(idx, 32'hFFFF_FFFE, "wrap_first_addr");
    wait_busy_low("wrap_busy_timeout");
    check("wrap_head", data_out, 32'h3E);
    req_at(idx + 1, 32'h0, "wrap_next_addr");

    // Seek while a request is in flight; its data must be discarded
    lat = 6;
    do_seek(32'h0000_0200);
    n = 0;
    while (!(mem_req && mem_addr == 32'h200) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("drain_req_seen", mem_addr, 32'h200);
    idx = req_log.size();
    do_seek(32'h0000_0300);
    seen = 1'b0;
    n = 0;
    while (data_busy && n < 200) begin
      seen |= (data_out == 8'hDE) || (data_out == 8'hAD);
      @(negedge CLK);
      n++;
    end
    repeat (10) begin
      seen |= (data_out == 8'hDE) || (data_out == 8'hAD);
      @(negedge CLK);
    end
    check("drain_stale_hidden", seen, 32'h0);
    check("drain_head", data_out, 32'h40);
    check("drain_next_addr", log_at(idx), 32'h300);

    // Reset for one cycle during an outstanding request
    n = 0;
    while (!mem_req && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("midreq_req_seen", mem_req, 32'h1);
    RST_N = 1'b0;
    #1;
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_busy", data_busy, 32'h1);
    check("midrst_mem_req", mem_req, 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    lat = 1;
    @(negedge CLK);
    check("midrst_req_held", mem_req, 32'h0);
    idx = req_log.size();
    RST_N = 1'b1;
    req_at(idx, 32'h0, "rerst_first_addr");
    wait_busy_low("rerst_busy_timeout");
    check("rerst_head", data_out, 32'h11);

    check("req_stable", stab_err, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/msu_data_prefetch.md
MSU_DATA_PREFETCH -- requirements
Module: msu_data_prefetch

Interface
REQ-001 Parameter: DEPTH, 8, byte capacity of the prefetch ring buffer (power of two, minimum 4).
REQ-002 Port: CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: RST_N  in  1  reset, asynchronous and active-low.
REQ-004 Port: seek  in  1  single-cycle pulse that loads a new data address.
REQ-005 Port: seek_addr  in  32  byte address, sampled when seek=1.
REQ-006 Port: rd_advance  in  1  single-cycle pulse: the SNES consumed the head byte.
REQ-007 Port: data_out  out  8  head byte of the buffer (the value read through $2001).
REQ-008 Port: data_busy  out  1  high while the head byte is not yet valid after a seek or reset.
REQ-009 Port: mem_req  out  1  word fetch request to the HPS/SDRAM side.
REQ-010 Port: mem_addr  out  32  byte address of the requested word; bit 0 is always 0.
REQ-011 Port: mem_ack  in  1  single-cycle pulse; mem_din is valid in that cycle.
REQ-012 Port: mem_din  in  16  fetched word; the low byte is at mem_addr and the high byte at mem_addr+1.

Function
REQ-013 FSM states:
- IDLE: no request outstanding.
- REQ: mem_req=1, waiting for ack.
- DRAIN: a stale request is outstanding after a seek; its data is discarded.
REQ-014 IDLE->REQ when free space (DEPTH-count) >=2 and no seek is in the same cycle; mem_req rises the cycle after the decision.
REQ-015 In REQ, mem_req and mem_addr shall stay stable until mem_ack.
- On mem_ack, write the low then the high byte (or only the high byte if skip_low=1).
- Then fetch_addr+=2 and return to IDLE.
REQ-016 mem_ack while mem_req=0 shall be ignored.
REQ-017 Seek handling:
- count:=0, rd/wr pointers:=0, fetch_addr:={seek_addr[31:1],0}, skip_low:=seek_addr[0], data_busy:=1.
- State:=DRAIN if a request is outstanding, else IDLE.
REQ-018 DRAIN: keep mem_req=1 until mem_ack, discard mem_din, then go to IDLE with the current fetch_addr.
REQ-019 A seek during DRAIN shall update the seek state (REQ-017) and remain in DRAIN.
REQ-020 data_busy falls in the cycle after the first post-seek byte is written (count becomes >=1).
REQ-021 rd_advance with count>=1 shall advance the read pointer and decrement count; with count=0 it shall be ignored (no underflow).
REQ-022 Pointers wrap modulo DEPTH; count range is 0..DEPTH and never exceeds DEPTH.
REQ-023 rd_advance and mem_ack in the same cycle shall both apply; count changes by the net amount (+1 or 0).
REQ-024 seek with rd_advance or mem_ack in the same cycle: seek wins; the other event is discarded (the ack still completes the handshake).
REQ-025 data_out is registered.
- Equals the buffer head byte one cycle after any change of head or count.
- Holds its last value when count=0.
REQ-026 fetch_addr is 32 bits and wraps from 0xFFFFFFFE to 0.

Reset
REQ-027 Reset values: data_out=0, data_busy=1, mem_req=0, mem_addr=0, count=0, pointers=0, skip_low=0, fetch_addr=0, state=IDLE.
REQ-028 After RST_N deasserts, behave as a seek to address 0 (first mem_req in the second cycle).
REQ-029 Reset mid-request abandons the request with no drain; the memory side shall drop a pending ack on reset.

Structure
REQ-030 Shared package msu_pkg shall hold: the FSM state enum, MSU_DATA_DEPTH default, and the word-width constant.
REQ-031 One sub-module, msu_byte_fifo, shall contain the ring buffer:
- Ports: wr strobe, rd strobe, flush, count.
- Strobes: two-byte write strobe and single-byte write strobe.
- The FSM, addressing and busy logic stay in msu_data_prefetch.

Verification
REQ-032 Reset, ack each request after 3 cycles, with mem_din=0x2211 @0, 0x4433 @2, 0x6655 @4, 0x8877 @6.
- Fetches stop at count=8 (mem_req stays 0).
- data_busy falls after the first ack.
- data_out=0x11.
REQ-033 seek 0x00000105 -> first mem_addr=0x104; with mem_din=0xAA99, only 0xAA is stored; data_out=0xAA; the next mem_addr is 0x106.
REQ-034 seek during REQ, then the stale ack returns 0xDEAD -> 0xDE and 0xAD are never visible on data_out; the next request is for the new address.
REQ-035 Full buffer, then 8 rd_advance pulses at 1 per cycle, with ack latency 1 -> data_out sequence matches address order; no byte lost or duplicated; count never exceeds 8.
REQ-036 rd_advance with count=0 while data_busy=1 -> count stays 0; the first valid byte after the fill is still byte 0 of the seek.
REQ-037 RST_N low for 1 cycle mid-REQ -> all outputs at reset values during reset; normal refill from 0 afterwards.
